// File: rtl/norm_share_arb.sv
// ----------------------------------------------------------------------------
// norm_share_arb
//
// Shares one combinational normalizeAndExpUpdate instance between two FMA
// lanes. Each lane offers an operand bundle with a valid/ready handshake; a
// round-robin arbiter picks one per cycle. The winner is registered onto the
// normalizer inputs (S1). The normalizer result is then captured, together
// with owner and tag, into a backpressured output register (S2).
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   reqN_*  (N=0,1)     lane operand bundle: valid/ready, prenorm, lza_shamt,
//                       shamt, cexp_small, res_exp, tag
//   nrm_*   (out)       S1 register contents driven to the normalizer
//   nrm_normalized/nrm_exp/nrm_exp_corr (in)  normalizer result
//   out_*               S2 result: valid/ready, owner, tag, normalized,
//                       exp, exp_corr
// ----------------------------------------------------------------------------
module norm_share_arb #(
    parameter int  SIG_WIDTH = 52,
    parameter int  EXP_WIDTH = 11,
    parameter int  TAG_W     = 4,
    localparam int PW        = 3 * (SIG_WIDTH + 1) + 8,
    localparam int NW        = SIG_WIDTH + 4
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [PW-1:0]        req0_prenorm,
    input  logic [6:0]           req0_lza_shamt,
    input  logic [6:0]           req0_shamt,
    input  logic                 req0_cexp_small,
    input  logic [EXP_WIDTH-1:0] req0_res_exp,
    input  logic [TAG_W-1:0]     req0_tag,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [PW-1:0]        req1_prenorm,
    input  logic [6:0]           req1_lza_shamt,
    input  logic [6:0]           req1_shamt,
    input  logic                 req1_cexp_small,
    input  logic [EXP_WIDTH-1:0] req1_res_exp,
    input  logic [TAG_W-1:0]     req1_tag,

    output logic [PW-1:0]        nrm_prenorm,
    output logic [6:0]           nrm_lza_shamt,
    output logic [6:0]           nrm_shamt,
    output logic                 nrm_cexp_small,
    output logic [EXP_WIDTH-1:0] nrm_res_exp,
    input  logic [NW-1:0]        nrm_normalized,
    input  logic [EXP_WIDTH-1:0] nrm_exp,
    input  logic                 nrm_exp_corr,

    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_owner,
    output logic [TAG_W-1:0]     out_tag,
    output logic [NW-1:0]        out_normalized,
    output logic [EXP_WIDTH-1:0] out_exp,
    output logic                 out_exp_corr
);

    // S1: registered winning bundle, drives the normalizer
    logic                 s1_valid_q,   s1_valid_d;
    logic                 s1_owner_q,   s1_owner_d;
    logic [PW-1:0]        s1_prenorm_q, s1_prenorm_d;
    logic [6:0]           s1_lza_q,     s1_lza_d;
    logic [6:0]           s1_shamt_q,   s1_shamt_d;
    logic                 s1_cexp_q,    s1_cexp_d;
    logic [EXP_WIDTH-1:0] s1_res_exp_q, s1_res_exp_d;
    logic [TAG_W-1:0]     s1_tag_q,     s1_tag_d;

    // S2: captured normalizer result
    logic                 s2_valid_q,   s2_valid_d;
    logic                 s2_owner_q,   s2_owner_d;
    logic [TAG_W-1:0]     s2_tag_q,     s2_tag_d;
    logic [NW-1:0]        s2_norm_q,    s2_norm_d;
    logic [EXP_WIDTH-1:0] s2_exp_q,     s2_exp_d;
    logic                 s2_corr_q,    s2_corr_d;

    logic                 last_grant_q, last_grant_d;

    logic s2_adv, s1_adv, s1_load;
    logic any_valid, sel, hs;

    always_comb begin
        s2_adv    = !s2_valid_q | out_ready;
        s1_adv    = s1_valid_q & s2_adv;
        // S1 may refill in the same cycle it hands its bundle to S2
        s1_load   = !s1_valid_q | s2_adv;
        any_valid = req0_valid | req1_valid;
        // Contention goes to the lane that did not win last; a lone
        // requester always wins. last_grant only moves on a handshake.
        sel       = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
        hs        = s1_load & any_valid;
    end

    assign req0_ready = s1_load & req0_valid & !sel;
    assign req1_ready = s1_load & req1_valid &  sel;

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_owner_d   = s1_owner_q;
        s1_prenorm_d = s1_prenorm_q;
        s1_lza_d     = s1_lza_q;
        s1_shamt_d   = s1_shamt_q;
        s1_cexp_d    = s1_cexp_q;
        s1_res_exp_d = s1_res_exp_q;
        s1_tag_d     = s1_tag_q;
        last_grant_d = last_grant_q;

        if (hs) begin
            s1_valid_d   = 1'b1;
            s1_owner_d   = sel;
            last_grant_d = sel;
            s1_prenorm_d = sel ? req1_prenorm    : req0_prenorm;
            s1_lza_d     = sel ? req1_lza_shamt  : req0_lza_shamt;
            s1_shamt_d   = sel ? req1_shamt      : req0_shamt;
            s1_cexp_d    = sel ? req1_cexp_small : req0_cexp_small;
            s1_res_exp_d = sel ? req1_res_exp    : req0_res_exp;
            s1_tag_d     = sel ? req1_tag        : req0_tag;
        end else if (s1_adv) begin
            // Data is left in place; only the valid bit drops
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_owner_d = s2_owner_q;
        s2_tag_d   = s2_tag_q;
        s2_norm_d  = s2_norm_q;
        s2_exp_d   = s2_exp_q;
        s2_corr_d  = s2_corr_q;

        if (s1_adv) begin
            s2_valid_d = 1'b1;
            s2_owner_d = s1_owner_q;
            s2_tag_d   = s1_tag_q;
            s2_norm_d  = nrm_normalized;
            s2_exp_d   = nrm_exp;
            s2_corr_d  = nrm_exp_corr;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_owner_q   <= 1'b0;
            s1_prenorm_q <= '0;
            s1_lza_q     <= '0;
            s1_shamt_q   <= '0;
            s1_cexp_q    <= 1'b0;
            s1_res_exp_q <= '0;
            s1_tag_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_owner_q   <= 1'b0;
            s2_tag_q     <= '0;
            s2_norm_q    <= '0;
            s2_exp_q     <= '0;
            s2_corr_q    <= 1'b0;
            // Lane 0 wins the first contention after reset
            last_grant_q <= 1'b1;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_owner_q   <= s1_owner_d;
            s1_prenorm_q <= s1_prenorm_d;
            s1_lza_q     <= s1_lza_d;
            s1_shamt_q   <= s1_shamt_d;
            s1_cexp_q    <= s1_cexp_d;
            s1_res_exp_q <= s1_res_exp_d;
            s1_tag_q     <= s1_tag_d;
            s2_valid_q   <= s2_valid_d;
            s2_owner_q   <= s2_owner_d;
            s2_tag_q     <= s2_tag_d;
            s2_norm_q    <= s2_norm_d;
            s2_exp_q     <= s2_exp_d;
            s2_corr_q    <= s2_corr_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign nrm_prenorm    = s1_prenorm_q;
    assign nrm_lza_shamt  = s1_lza_q;
    assign nrm_shamt      = s1_shamt_q;
    assign nrm_cexp_small = s1_cexp_q;
    assign nrm_res_exp    = s1_res_exp_q;

    assign out_valid      = s2_valid_q;
    assign out_owner      = s2_owner_q;
    assign out_tag        = s2_tag_q;
    assign out_normalized = s2_norm_q;
    assign out_exp        = s2_exp_q;
    assign out_exp_corr   = s2_corr_q;

endmodule

// File: tb/tb_norm_share_arb.sv
module tb_norm_share_arb;

    localparam int SW = 52;
    localparam int EW = 11;
    localparam int TW = 4;
    localparam int PW = 3 * (SW + 1) + 8;
    localparam int NW = SW + 4;
    localparam int RW = 1 + TW + NW + EW + 1;

    logic          clk, rst;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [PW-1:0] req0_prenorm, req1_prenorm;
    logic [6:0]    req0_lza_shamt, req1_lza_shamt, req0_shamt, req1_shamt;
    logic          req0_cexp_small, req1_cexp_small;
    logic [EW-1:0] req0_res_exp, req1_res_exp;
    logic [TW-1:0] req0_tag, req1_tag;
    logic [PW-1:0] nrm_prenorm;
    logic [6:0]    nrm_lza_shamt, nrm_shamt;
    logic          nrm_cexp_small;
    logic [EW-1:0] nrm_res_exp;
    logic [NW-1:0] nrm_normalized;
    logic [EW-1:0] nrm_exp;
    logic          nrm_exp_corr;
    logic          out_valid, out_ready, out_owner, out_exp_corr;
    logic [TW-1:0] out_tag;
    logic [NW-1:0] out_normalized;
    logic [EW-1:0] out_exp;

    int n_cmp = 0;
    int n_err = 0;

    norm_share_arb #(.SIG_WIDTH(SW), .EXP_WIDTH(EW), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_prenorm(req0_prenorm),
        .req0_lza_shamt(req0_lza_shamt), .req0_shamt(req0_shamt),
        .req0_cexp_small(req0_cexp_small), .req0_res_exp(req0_res_exp), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_prenorm(req1_prenorm),
        .req1_lza_shamt(req1_lza_shamt), .req1_shamt(req1_shamt),
        .req1_cexp_small(req1_cexp_small), .req1_res_exp(req1_res_exp), .req1_tag(req1_tag),
        .nrm_prenorm(nrm_prenorm), .nrm_lza_shamt(nrm_lza_shamt), .nrm_shamt(nrm_shamt),
        .nrm_cexp_small(nrm_cexp_small), .nrm_res_exp(nrm_res_exp),
        .nrm_normalized(nrm_normalized), .nrm_exp(nrm_exp), .nrm_exp_corr(nrm_exp_corr),
        .out_valid(out_valid), .out_ready(out_ready), .out_owner(out_owner), .out_tag(out_tag),
        .out_normalized(out_normalized), .out_exp(out_exp), .out_exp_corr(out_exp_corr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in normalizer: every input field influences the result so that
    // any misrouted field shows up at the output.
    function automatic logic [NW+EW:0] nrm_model(input logic [PW-1:0] p, input logic [6:0] lza,
                                                 input logic [6:0] sh, input logic ce,
                                                 input logic [EW-1:0] re);
        logic [PW-1:0] t;
        logic [NW-1:0] n;
        logic [EW-1:0] e;
        logic          c;
        t = p << lza;
        n = t[PW-1 -: NW] ^ NW'({sh, ce});
        e = re - EW'(lza) + EW'(ce);
        c = t[PW-1] ^ p[0];
        return {n, e, c};
    endfunction

    always_comb begin
        {nrm_normalized, nrm_exp, nrm_exp_corr} =
            nrm_model(nrm_prenorm, nrm_lza_shamt, nrm_shamt, nrm_cexp_small, nrm_res_exp);
    end

    typedef struct {
        logic [PW-1:0] p;
        logic [6:0]    lza;
        logic [6:0]    sh;
        logic          ce;
        logic [EW-1:0] re;
        logic [TW-1:0] tag;
    } bundle_t;

    function automatic bundle_t mk_bundle(input int lane, input logic [TW-1:0] tag);
        logic [31:0]  s;
        logic [191:0] w;
        bundle_t      b;
        s = 32'(lane * 16 + int'(tag)) * 32'h9E3779B9 + 32'h01234567;
        w = {s, ~s, s ^ 32'h5A5A5A5A, s + 32'd77, {s[15:0], s[31:16]}, s * 32'd3};
        b.p   = w[PW-1:0];
        b.lza = 7'(s % 32'd60);
        b.sh  = s[14:8];
        b.ce  = s[3];
        b.re  = s[26:16];
        b.tag = tag;
        return b;
    endfunction

    function automatic bundle_t rnd_bundle();
        logic [191:0] w;
        bundle_t      b;
        w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        b.p   = w[PW-1:0];
        b.lza = 7'($urandom());
        b.sh  = 7'($urandom());
        b.ce  = 1'($urandom());
        b.re  = EW'($urandom());
        b.tag = TW'($urandom());
        return b;
    endfunction

    function automatic logic [RW-1:0] exp_result(input logic owner, input bundle_t b);
        return {owner, b.tag, nrm_model(b.p, b.lza, b.sh, b.ce, b.re)};
    endfunction

    function automatic logic [RW-1:0] act_result();
        return {out_owner, out_tag, out_normalized, out_exp, out_exp_corr};
    endfunction

    task automatic set_lane(input int lane, input logic v, input bundle_t b);
        if (lane == 0) begin
            req0_valid = v; req0_prenorm = b.p; req0_lza_shamt = b.lza;
            req0_shamt = b.sh; req0_cexp_small = b.ce; req0_res_exp = b.re; req0_tag = b.tag;
        end else begin
            req1_valid = v; req1_prenorm = b.p; req1_lza_shamt = b.lza;
            req1_shamt = b.sh; req1_cexp_small = b.ce; req1_res_exp = b.re; req1_tag = b.tag;
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic v0, v1, ordy;
        logic r0, r1, ov;
        logic own;
        logic [TW-1:0] tag;
    } vec_t;

    vec_t    tbl[26];
    bundle_t b0, b1;
    logic [RW-1:0] sb[$];
    logic [RW-1:0] e;
    logic [TW-1:0] t0, t1;
    logic    hs0, hs1, pend0, pend1, hsout;

    initial begin
        // cycle table: inputs {v0,v1,out_ready}, expected {ready0,ready1,out_valid,owner,tag}
        tbl[0]  = '{1,1,1, 1,0,0, 0,0};   // contention: lane 0 first after reset
        tbl[1]  = '{1,1,1, 0,1,0, 0,0};
        tbl[2]  = '{1,1,1, 1,0,1, 0,0};
        tbl[3]  = '{1,1,1, 0,1,1, 1,8};
        tbl[4]  = '{1,1,1, 1,0,1, 0,1};
        tbl[5]  = '{0,0,1, 0,0,1, 1,9};
        tbl[6]  = '{0,0,1, 0,0,1, 0,2};
        tbl[7]  = '{0,0,1, 0,0,0, 0,0};
        tbl[8]  = '{1,1,0, 0,1,0, 0,0};   // backpressure: two accepted then stall
        tbl[9]  = '{1,1,0, 1,0,0, 0,0};
        tbl[10] = '{1,1,0, 0,0,1, 1,10};
        tbl[11] = '{1,1,0, 0,0,1, 1,10};
        tbl[12] = '{1,1,0, 0,0,1, 1,10};
        tbl[13] = '{1,1,1, 0,1,1, 1,10};  // release
        tbl[14] = '{1,0,1, 1,0,1, 0,3};
        tbl[15] = '{0,0,1, 0,0,1, 1,11};
        tbl[16] = '{0,0,1, 0,0,1, 0,4};
        tbl[17] = '{0,0,1, 0,0,0, 0,0};
        tbl[18] = '{0,1,1, 0,1,0, 0,0};   // lane 1 alone, then lane 0 wins
        tbl[19] = '{0,1,1, 0,1,0, 0,0};
        tbl[20] = '{0,1,1, 0,1,1, 1,12};
        tbl[21] = '{1,1,1, 1,0,1, 1,13};
        tbl[22] = '{1,1,1, 0,1,1, 1,14};
        tbl[23] = '{0,0,1, 0,0,1, 0,5};
        tbl[24] = '{0,0,1, 0,0,1, 1,15};
        tbl[25] = '{0,0,1, 0,0,0, 0,0};

        // ---- reset state ----
        rst = 1'b1; out_ready = 1'b1;
        set_lane(0, 1'b0, mk_bundle(0, 0));
        set_lane(1, 1'b0, mk_bundle(1, 0));
        repeat (2) @(negedge clk);
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_out_fields", 128'(act_result()), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        // ---- single lane, tag 3 ----
        b0 = mk_bundle(0, 3);
        set_lane(0, 1'b1, b0);
        #1 chk("single_ready0", 128'({req0_ready, req1_ready}), 128'(2'b10));
        @(negedge clk);
        set_lane(0, 1'b0, b0);
        #1 chk("single_ov_1edge", 128'(out_valid), 128'(0));
        @(negedge clk);
        #1 chk("single_ov_2edge", 128'(out_valid), 128'(1));
        chk("single_result", 128'(act_result()), 128'(exp_result(1'b0, b0)));
        $display("single: owner=%0d tag=%0d exp=%0h", out_owner, out_tag, out_exp);
        @(negedge clk);
        #1 chk("single_drained", 128'(out_valid), 128'(0));

        // ---- reset with S1 and S2 full ----
        out_ready = 1'b0;
        set_lane(0, 1'b1, mk_bundle(0, 6));
        set_lane(1, 1'b1, mk_bundle(1, 7));
        repeat (2) @(negedge clk);
        #1 chk("full_ready", 128'({req0_ready, req1_ready}), 128'(2'b00));
        chk("full_out_valid", 128'(out_valid), 128'(1));
        rst = 1'b1;
        #1 chk("midrst_out_valid", 128'(out_valid), 128'(0));
        chk("midrst_out_fields", 128'(act_result()), 128'(0));
        chk("midrst_ready", 128'({req0_ready, req1_ready}), 128'(2'b10));
        @(negedge clk);
        set_lane(0, 1'b0, mk_bundle(0, 6));
        set_lane(1, 1'b0, mk_bundle(1, 7));
        out_ready = 1'b1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk("postrst_no_result", 128'(out_valid), 128'(0));

        // ---- table: contention, backpressure, fairness ----
        t0 = 4'd0; t1 = 4'd8;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            b0 = mk_bundle(0, t0);
            b1 = mk_bundle(1, t1);
            set_lane(0, tbl[i].v0, b0);
            set_lane(1, tbl[i].v1, b1);
            out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("row%0d_ready", i), 128'({req0_ready, req1_ready}),
                128'({tbl[i].r0, tbl[i].r1}));
            chk($sformatf("row%0d_out_valid", i), 128'(out_valid), 128'(tbl[i].ov));
            if (tbl[i].ov) begin
                chk($sformatf("row%0d_result", i), 128'(act_result()),
                    128'(exp_result(tbl[i].own, mk_bundle(int'(tbl[i].own), tbl[i].tag))));
            end
            $display("row %0d: v=%b%b ordy=%b ready=%b%b out_valid=%b owner=%0d tag=%0d",
                     i, tbl[i].v0, tbl[i].v1, tbl[i].ordy, req0_ready, req1_ready,
                     out_valid, out_owner, out_tag);
            hs0 = req0_valid & req0_ready;
            hs1 = req1_valid & req1_ready;
            @(posedge clk);
            if (hs0) t0 = t0 + 4'd1;
            if (hs1) t1 = t1 + 4'd1;
        end

        // ---- random traffic with in-order scoreboard ----
        pend0 = 1'b0; pend1 = 1'b0;
        for (int c = 0; c < 10050; c++) begin
            @(negedge clk);
            if (c < 10000) begin
                if (!pend0 && ($urandom_range(2) != 0)) begin b0 = rnd_bundle(); pend0 = 1'b1; end
                if (!pend1 && ($urandom_range(2) != 0)) begin b1 = rnd_bundle(); pend1 = 1'b1; end
                out_ready = ($urandom_range(3) != 0);
            end else begin
                out_ready = 1'b1;
                if (!pend0 && !pend1 && !out_valid && sb.size() == 0) break;
            end
            set_lane(0, pend0, b0);
            set_lane(1, pend1, b1);
            #1;
            if ((req0_ready & req1_ready) | (req0_ready & !req0_valid) | (req1_ready & !req1_valid))
                chk("rnd_ready_legal", 128'({req0_ready, req1_ready}), 128'({req0_valid, req1_valid}));
            hs0 = req0_valid & req0_ready;
            hs1 = req1_valid & req1_ready;
            hsout = out_valid & out_ready;
            if (hs0) sb.push_back(exp_result(1'b0, b0));
            if (hs1) sb.push_back(exp_result(1'b1, b1));
            if (hsout) begin
                if (sb.size() == 0) begin
                    chk("rnd_unexpected_result", 128'(act_result()), 128'(0) - 128'(1));
                end else begin
                    e = sb.pop_front();
                    chk("rnd_result", 128'(act_result()), 128'(e));
                    $display("rnd result: owner=%0d tag=%0d exp=%0h", out_owner, out_tag, out_exp);
                end
            end
            @(posedge clk);
            if (hs0) pend0 = 1'b0;
            if (hs1) pend1 = 1'b0;
        end
        chk("rnd_all_drained", 128'(sb.size()), 128'(0));
        chk("rnd_lanes_idle", 128'({pend0, pend1}), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
